// File: rtl/issue_stage_pkg.sv
// rtl/issue_stage_pkg.sv - shared widths and register index type for the issue stage
package issue_stage_pkg;
    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int CODELEN = 12;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/issue_stage_regfile.sv
// rtl/issue_stage_regfile.sv - 2-read/1-write register file, x0 reads as zero
module issue_stage_regfile
    import issue_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  reg_idx_t        ra1,
    output logic [XLEN-1:0] rd1,
    input  reg_idx_t        ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  reg_idx_t        wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != REG_ZERO) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == REG_ZERO) ? '0 : regs[ra1];
    assign rd2 = (ra2 == REG_ZERO) ? '0 : regs[ra2];
endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - operand read, busy scoreboard and single-entry issue register
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [CODELEN-1:0] in_code,
    input  logic               in_is_load,
    input  logic               in_is_branch,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [31:0]        ex_pc,
    output logic [4:0]         ex_rd,
    output logic [XLEN-1:0]    ex_imm,
    output logic [CODELEN-1:0] ex_code,
    output logic               ex_is_load,
    output logic               ex_is_branch,
    output logic [XLEN-1:0]    ex_rs1_val,
    output logic [XLEN-1:0]    ex_rs2_val
);
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  rf_rd1, rf_rd2;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             slot_free, hazard, issue;
    logic             wb_hit_rs1, wb_hit_rs2, wb_hit_rd;

    issue_stage_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (in_rs1),
        .rd1   (rf_rd1),
        .ra2   (in_rs2),
        .rd2   (rf_rd2),
        .we    (wb_en),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    assign wb_hit_rs1 = wb_en && (wb_rd == in_rs1);
    assign wb_hit_rs2 = wb_en && (wb_rd == in_rs2);
    assign wb_hit_rd  = wb_en && (wb_rd == in_rd);

    // A writeback landing this cycle releases its register early, so it never blocks.
    always_comb begin
        hazard = 1'b0;
        if (in_valid) begin
            hazard = ((in_rs1 != REG_ZERO) && busy[in_rs1] && !wb_hit_rs1) ||
                     ((in_rs2 != REG_ZERO) && busy[in_rs2] && !wb_hit_rs2) ||
                     ((in_rd  != REG_ZERO) && busy[in_rd]  && !wb_hit_rd);
        end
    end

    assign slot_free = !ex_valid || ex_ready;
    assign in_ready  = slot_free && !hazard && !flush;
    assign issue     = in_valid && in_ready;

    assign rs1_val = (in_rs1 == REG_ZERO) ? '0 : (wb_hit_rs1 ? wb_data : rf_rd1);
    assign rs2_val = (in_rs2 == REG_ZERO) ? '0 : (wb_hit_rs2 ? wb_data : rf_rd2);

    // Clear first, set second: a same-edge issue to the writeback target stays busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (issue && in_rd == reg_idx_t'(i)) begin
                    busy[i] <= 1'b1;
                end else if (wb_en && wb_rd == reg_idx_t'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_imm       <= '0;
            ex_code      <= '0;
            ex_is_load   <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid     <= 1'b1;
            ex_pc        <= in_pc;
            ex_rd        <= in_rd;
            ex_imm       <= in_imm;
            ex_code      <= in_code;
            ex_is_load   <= in_is_load;
            ex_is_branch <= in_is_branch;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
        end else if (slot_free) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - directed self-checking bench for issue_stage
module tb_issue_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic [11:0] in_code;
    logic        in_is_load, in_is_branch, flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [11:0] ex_code;
    logic        ex_is_load, ex_is_branch;
    logic [31:0] ex_rs1_val, ex_rs2_val;

    int tests = 0;
    int fails = 0;

    issue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .in_code      (in_code),
        .in_is_load   (in_is_load),
        .in_is_branch (in_is_branch),
        .flush        (flush),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_rd        (ex_rd),
        .ex_imm       (ex_imm),
        .ex_code      (ex_code),
        .ex_is_load   (ex_is_load),
        .ex_is_branch (ex_is_branch),
        .ex_rs1_val   (ex_rs1_val),
        .ex_rs2_val   (ex_rs2_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] pc);
        in_valid = v;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_pc    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        in_imm = 32'h0; in_code = 12'h0; in_is_load = 1'b0; in_is_branch = 1'b0;
        flush = 1'b0; ex_ready = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_pc", ex_pc, 32'h0);
        chk("rst_ex_rs1", ex_rs1_val, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b1;

        // 1: ADDI x5, x0, 7
        tick();
        drive(1'b1, 5'd5, 5'd0, 5'd0, 32'h10);
        in_imm = 32'd7; in_code = 12'h013;
        #1 chk("t1_in_ready", in_ready, 1'b1);
        tick();
        chk("t1_ex_valid", ex_valid, 1'b1);
        chk("t1_ex_rd", ex_rd, 32'd5);
        chk("t1_ex_rs1", ex_rs1_val, 32'h0);
        chk("t1_ex_pc", ex_pc, 32'h10);
        chk("t1_ex_imm", ex_imm, 32'd7);
        chk("t1_ex_code", ex_code, 32'h013);

        // 2: RAW on x5 until writeback bypass
        drive(1'b1, 5'd6, 5'd5, 5'd0, 32'h14);
        #1 chk("t2_stall", in_ready, 1'b0);
        tick();
        chk("t2_stall2", in_ready, 1'b0);
        chk("t2_bubble", ex_valid, 1'b0);
        wb(1'b1, 5'd5, 32'h2A);
        #1 chk("t2_wb_release", in_ready, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t2_ex_valid", ex_valid, 1'b1);
        chk("t2_bypass", ex_rs1_val, 32'h2A);
        chk("t2_ex_rd", ex_rd, 32'd6);

        // 3: back-pressure holds the output register
        ex_ready = 1'b0;
        drive(1'b1, 5'd7, 5'd0, 5'd5, 32'h18);
        #1 chk("t3_stall", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_pc", ex_pc, 32'h14);
            chk("t3_hold_valid", ex_valid, 1'b1);
        end
        ex_ready = 1'b1;
        #1 chk("t3_release", in_ready, 1'b1);
        tick();
        chk("t3_ex_pc", ex_pc, 32'h18);
        chk("t3_rf_read", ex_rs2_val, 32'h2A);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        wb(1'b1, 5'd6, 32'h66);
        tick();
        wb(1'b1, 5'd7, 32'h77);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t3_drain", ex_valid, 1'b0);

        // 4: load then flush
        drive(1'b1, 5'd3, 5'd0, 5'd0, 32'h20);
        in_is_load = 1'b1;
        tick();
        chk("t4_load_valid", ex_valid, 1'b1);
        chk("t4_is_load", ex_is_load, 1'b1);
        in_is_load = 1'b0;
        drive(1'b1, 5'd8, 5'd6, 5'd0, 32'h24);
        flush = 1'b1;
        #1 chk("t4_flush_block", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        chk("t4_flushed", ex_valid, 1'b0);
        drive(1'b1, 5'd0, 5'd3, 5'd0, 32'h28);
        #1 chk("t4_busy3", in_ready, 1'b0);
        drive(1'b1, 5'd8, 5'd0, 5'd0, 32'h28);
        #1 chk("t4_rd8_free", in_ready, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        wb(1'b1, 5'd3, 32'h33);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd0, 5'd3, 5'd6, 32'h2C);
        #1 chk("t4_busy3_clear", in_ready, 1'b1);
        tick();
        chk("t4_rs1_val", ex_rs1_val, 32'h33);
        chk("t4_rs2_val", ex_rs2_val, 32'h66);

        // 5: writes to x0 are ignored, x0 never busy
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h30);
        #1 chk("t5_x0_ready", in_ready, 1'b1);
        tick();
        chk("t5_x0_bypass", ex_rs1_val, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h34);
        #1 chk("t5_rd0_nostall", in_ready, 1'b1);
        tick();
        chk("t5_x0_read", ex_rs1_val, 32'h0);
        chk("t5_ex_pc", ex_pc, 32'h34);

        // 6: same-edge clear/set on x7, then reset while stalled
        drive(1'b1, 5'd7, 5'd0, 5'd0, 32'h40);
        tick();
        wb(1'b1, 5'd7, 32'h70);
        drive(1'b1, 5'd7, 5'd0, 5'd0, 32'h44);
        #1 chk("t6_waw_bypass", in_ready, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("t6_ex_rd", ex_rd, 32'd7);
        drive(1'b1, 5'd0, 5'd7, 5'd0, 32'h48);
        #1 chk("t6_busy7_kept", in_ready, 1'b0);
        ex_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h48);
        #1 chk("t6_slot_stall", in_ready, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", ex_valid, 1'b0);
        chk("t6_rst_pc", ex_pc, 32'h0);
        chk("t6_rst_rd", ex_rd, 32'd0);
        tick();
        reset = 1'b1;
        ex_ready = 1'b1;
        drive(1'b1, 5'd0, 5'd7, 5'd5, 32'h50);
        #1 chk("t6_busy_cleared", in_ready, 1'b1);
        tick();
        chk("t6_rf_cleared", ex_rs2_val, 32'h0);
        chk("t6_rf_cleared7", ex_rs1_val, 32'h0);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
